stopwatch_ctrl: RTL and testbench

//  Control FSM for the DE1 stopwatch/clock datapath (centisecond/second/minute/hour CounterX chain).

---
 rtl/stopwatch_ctrl_pkg.sv | 21 ++
 rtl/stopwatch_ctrl_key_conditioner.sv | 44 ++++
 rtl/stopwatch_ctrl.sv | 153 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared state codes, blank masks and the set-mode wrap helper for the stopwatch controller.
package stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_STOP     = 2'd0,
        ST_RUN      = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_SET_HOUR = 2'd3
    } state_t;

    localparam logic [3:0] MASK_MIN  = 4'b0011;
    localparam logic [3:0] MASK_HOUR = 4'b1100;

    // Out-of-range presets (from a live count above the modulus) fall back to 0.
    function automatic logic [7:0] wrap_inc(input logic [7:0] val, input logic [7:0] max);
        logic [7:0] nxt;
        nxt = val + 8'd1;
        return ((nxt == max) || (val >= max)) ? 8'd0 : nxt;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_key_conditioner.sv
// Raw active-low key -> 2-FF synchroniser, Tick-sampled debounce, one-clock press pulse on accepted 1->0.
module key_conditioner #(
    parameter int DEB_TICKS = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic tick,
    input  logic key_n,
    output logic press
);

    logic [1:0] sync;
    logic       cand;
    logic       level;
    logic       level_d;
    logic [3:0] deb_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync    <= 2'b11;
            cand    <= 1'b1;
            level   <= 1'b1;
            level_d <= 1'b1;
            deb_cnt <= 4'd0;
        end else begin
            sync    <= {sync[0], key_n};
            level_d <= level;
            if (tick) begin
                // Down-counter reloads on every sample change; terminal count accepts the candidate.
                if (sync[1] != cand) begin
                    cand    <= sync[1];
                    deb_cnt <= 4'(DEB_TICKS - 1);
                    if (DEB_TICKS == 1) level <= sync[1];
                end else begin
                    if (deb_cnt == 4'd1) level <= cand;
                    if (deb_cnt != 4'd0) deb_cnt <= deb_cnt - 4'd1;
                end
            end
        end
    end

    assign press = level_d & ~level;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch/clock control FSM: run/stop, clear, time-set and page select from three debounced keys.
// Optional build macro LAP_FREEZE_EN: in RUN, inc toggles Freeze instead of the display page.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int DEB_TICKS   = 2,
    parameter int BLINK_TICKS = 50,
    parameter int MIN_MAX     = 60,
    parameter int HOUR_MAX    = 12
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       key_start_n,
    input  logic       key_mode_n,
    input  logic       key_inc_n,
    input  logic [7:0] cur_min,
    input  logic [7:0] cur_hour,
    output logic       run_en,
    output logic       clr,
    output logic [7:0] set_min,
    output logic [7:0] set_hour,
    output logic       load_min,
    output logic       load_hour,
    output logic       disp_sel,
    output logic [3:0] blank_mask,
    output logic       freeze,
    output logic [1:0] state
);

    localparam logic [15:0] BLINK_LOAD = 16'(BLINK_TICKS - 1);
    localparam logic [7:0]  MIN_MOD    = 8'(MIN_MAX);
    localparam logic [7:0]  HOUR_MOD   = 8'(HOUR_MAX);

    state_t      st;
    logic [15:0] blink_cnt;
    logic        phase;
    logic        p_start, p_mode, p_inc;
    logic        go_start, go_mode, go_inc;

    key_conditioner #(.DEB_TICKS(DEB_TICKS)) u_key_start (
        .clock(clock), .reset_n(reset_n), .tick(tick), .key_n(key_start_n), .press(p_start));
    key_conditioner #(.DEB_TICKS(DEB_TICKS)) u_key_mode (
        .clock(clock), .reset_n(reset_n), .tick(tick), .key_n(key_mode_n), .press(p_mode));
    key_conditioner #(.DEB_TICKS(DEB_TICKS)) u_key_inc (
        .clock(clock), .reset_n(reset_n), .tick(tick), .key_n(key_inc_n), .press(p_inc));

    // Same-cycle presses: start wins, then mode; losers are dropped.
    assign go_start = p_start;
    assign go_mode  = p_mode & ~p_start;
    assign go_inc   = p_inc & ~p_start & ~p_mode;

`ifdef LAP_FREEZE_EN
    logic freeze_q;
    assign freeze = freeze_q;
`else
    assign freeze = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            st        <= ST_STOP;
            run_en    <= 1'b0;
            clr       <= 1'b0;
            set_min   <= 8'd0;
            set_hour  <= 8'd0;
            load_min  <= 1'b0;
            load_hour <= 1'b0;
            disp_sel  <= 1'b0;
            blink_cnt <= BLINK_LOAD;
            phase     <= 1'b0;
`ifdef LAP_FREEZE_EN
            freeze_q  <= 1'b0;
`endif
        end else begin
            clr       <= 1'b0;
            load_min  <= 1'b0;
            load_hour <= 1'b0;
            if (tick) begin
                if (blink_cnt == 16'd0) begin
                    blink_cnt <= BLINK_LOAD;
                    phase     <= ~phase;
                end else begin
                    blink_cnt <= blink_cnt - 16'd1;
                end
            end
            case (st)
                ST_STOP: begin
                    if (go_start) begin
                        st     <= ST_RUN;
                        run_en <= 1'b1;
                    end else if (go_mode) begin
                        st        <= ST_SET_MIN;
                        set_min   <= cur_min;
                        set_hour  <= cur_hour;
                        disp_sel  <= 1'b1;
                        blink_cnt <= BLINK_LOAD;
                        phase     <= 1'b0;
                    end else if (go_inc) begin
                        clr <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (go_start) begin
                        st     <= ST_STOP;
                        run_en <= 1'b0;
`ifdef LAP_FREEZE_EN
                        freeze_q <= 1'b0;
`endif
                    end else if (go_inc) begin
`ifdef LAP_FREEZE_EN
                        freeze_q <= ~freeze_q;
`else
                        disp_sel <= ~disp_sel;
`endif
                    end
                end
                ST_SET_MIN: begin
                    if (go_start) begin
                        st <= ST_STOP;
                    end else if (go_mode) begin
                        st        <= ST_SET_HOUR;
                        blink_cnt <= BLINK_LOAD;
                        phase     <= 1'b0;
                    end else if (go_inc) begin
                        set_min  <= wrap_inc(set_min, MIN_MOD);
                        load_min <= 1'b1;
                    end
                end
                ST_SET_HOUR: begin
                    if (go_start || go_mode) begin
                        st <= ST_STOP;
                    end else if (go_inc) begin
                        set_hour  <= wrap_inc(set_hour, HOUR_MOD);
                        load_hour <= 1'b1;
                    end
                end
                default: st <= ST_STOP;
            endcase
        end
    end

    always_comb begin
        blank_mask = 4'b0000;
        if (phase) begin
            if (st == ST_SET_MIN)  blank_mask = MASK_MIN;
            if (st == ST_SET_HOUR) blank_mask = MASK_HOUR;
        end
    end

    assign state = st;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl (DEB_TICKS=2, BLINK_TICKS=4, Tick every 10 clocks).
module tb_stopwatch_ctrl;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick = 1'b0;
    logic       key_start_n = 1'b1;
    logic       key_mode_n = 1'b1;
    logic       key_inc_n = 1'b1;
    logic [7:0] cur_min = 8'd0;
    logic [7:0] cur_hour = 8'd0;
    logic       run_en, clr, load_min, load_hour, disp_sel, freeze;
    logic [7:0] set_min, set_hour;
    logic [3:0] blank_mask;
    logic [1:0] state;

    int vectors = 0;
    int miscompares = 0;
    int clr_cnt = 0;
    int overlap_cnt = 0;
    int bad_load_cnt = 0;
    int state_changes = 0;
    time last_change = 0;
    logic [1:0] prev_state = 2'd0;
    logic [3:0] entry_blank_hour = 4'hF;
    logic [7:0] min_exp[$], min_obs[$], hour_exp[$], hour_obs[$];

    stopwatch_ctrl #(.DEB_TICKS(2), .BLINK_TICKS(4), .MIN_MAX(60), .HOUR_MAX(12)) dut (
        .clock(clock), .reset_n(reset_n), .tick(tick),
        .key_start_n(key_start_n), .key_mode_n(key_mode_n), .key_inc_n(key_inc_n),
        .cur_min(cur_min), .cur_hour(cur_hour),
        .run_en(run_en), .clr(clr), .set_min(set_min), .set_hour(set_hour),
        .load_min(load_min), .load_hour(load_hour), .disp_sel(disp_sel),
        .blank_mask(blank_mask), .freeze(freeze), .state(state));

    always #5 clock = ~clock;

    initial begin
        forever begin
            repeat (9) @(negedge clock);
            tick = 1'b1;
            @(negedge clock);
            tick = 1'b0;
        end
    end

    // Observed-side capture for the scoreboard and global invariants.
    always @(negedge clock) begin
        if (load_min)  min_obs.push_back(set_min);
        if (load_hour) hour_obs.push_back(set_hour);
        if (clr) clr_cnt++;
        if (clr && (load_min || load_hour)) overlap_cnt++;
        if ((load_min || load_hour) && (state == 2'd0 || state == 2'd1)) bad_load_cnt++;
        if (state !== prev_state) begin
            state_changes++;
            last_change = $time;
            if (state == 2'd3) entry_blank_hour = blank_mask;
        end
        prev_state = state;
    end

    task automatic press_keys(input logic s, input logic m, input logic i);
        @(negedge clock);
        key_start_n = ~s;
        key_mode_n  = ~m;
        key_inc_n   = ~i;
        repeat (50) @(negedge clock);
        key_start_n = 1'b1;
        key_mode_n  = 1'b1;
        key_inc_n   = 1'b1;
        repeat (50) @(negedge clock);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        vectors++;
        if (state !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", state); end
        vectors++;
        if (run_en !== 1'b0) begin miscompares++; $display("FAIL reset_run_en: got %b expected 0", run_en); end
        vectors++;
        if ({clr, load_min, load_hour, disp_sel, freeze} !== 5'b0) begin
            miscompares++; $display("FAIL reset_strobes: got %b expected 00000", {clr, load_min, load_hour, disp_sel, freeze});
        end
        vectors++;
        if ({set_min, set_hour, blank_mask} !== 20'h0) begin
            miscompares++; $display("FAIL reset_values: got %h expected 00000", {set_min, set_hour, blank_mask});
        end
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
    endtask

    task automatic test_start_run;
        press_keys(1'b1, 1'b0, 1'b0);
        vectors++;
        if (state !== 2'd1) begin miscompares++; $display("FAIL start_state: got %0d expected 1", state); end
        vectors++;
        if (run_en !== 1'b1) begin miscompares++; $display("FAIL start_run_en: got %b expected 1", run_en); end
        vectors++;
        if (state_changes != 1) begin miscompares++; $display("FAIL start_single_press: got %0d changes expected 1", state_changes); end
        vectors++;
        if (clr_cnt != 0) begin miscompares++; $display("FAIL start_no_clr: got %0d expected 0", clr_cnt); end
        press_keys(1'b1, 1'b0, 1'b0);
        vectors++;
        if ({state, run_en} !== 3'b000) begin miscompares++; $display("FAIL stop_state: got %b expected 000", {state, run_en}); end
    endtask

    task automatic test_bounce;
        int  c0;
        time t_stable;
        c0 = state_changes;
        @(negedge clock);
        key_start_n = 1'b0;
        repeat (3) @(negedge clock);
        key_start_n = 1'b1;
        repeat (3) @(negedge clock);
        key_start_n = 1'b0;
        t_stable = $time;
        repeat (50) @(negedge clock);
        key_start_n = 1'b1;
        repeat (50) @(negedge clock);
        vectors++;
        if (state_changes - c0 != 1) begin miscompares++; $display("FAIL bounce_single: got %0d changes expected 1", state_changes - c0); end
        vectors++;
        if (last_change <= t_stable) begin miscompares++; $display("FAIL bounce_timing: got change at %0t expected after %0t", last_change, t_stable); end
        vectors++;
        if (state !== 2'd1) begin miscompares++; $display("FAIL bounce_state: got %0d expected 1", state); end
        press_keys(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_clear;
        int c;
        c = clr_cnt;
        press_keys(1'b0, 1'b0, 1'b1);
        vectors++;
        if (clr_cnt != c + 1) begin miscompares++; $display("FAIL clear_pulse: got %0d pulses expected 1", clr_cnt - c); end
        vectors++;
        if (state !== 2'd0) begin miscompares++; $display("FAIL clear_state: got %0d expected 0", state); end
    endtask

    task automatic test_set_min;
        logic [7:0] e, o;
        cur_min  = 8'd58;
        cur_hour = 8'd11;
        press_keys(1'b0, 1'b1, 1'b0);
        vectors++;
        if ({state, disp_sel} !== 3'b101) begin miscompares++; $display("FAIL setmin_entry: got %b expected 101", {state, disp_sel}); end
        vectors++;
        if ({set_min, set_hour} !== {8'd58, 8'd11}) begin
            miscompares++; $display("FAIL setmin_capture: got %0d:%0d expected 11:58", set_hour, set_min);
        end
        min_exp.push_back(8'd59); press_keys(1'b0, 1'b0, 1'b1);
        min_exp.push_back(8'd0);  press_keys(1'b0, 1'b0, 1'b1);
        min_exp.push_back(8'd1);  press_keys(1'b0, 1'b0, 1'b1);
        vectors++;
        if (min_obs.size() != 3) begin miscompares++; $display("FAIL setmin_loads: got %0d expected 3", min_obs.size()); end
        while (min_exp.size() > 0 && min_obs.size() > 0) begin
            e = min_exp.pop_front();
            o = min_obs.pop_front();
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL setmin_value: got %0d expected %0d", o, e); end
        end
        min_exp.delete();
        min_obs.delete();
        vectors++;
        if (hour_obs.size() != 0 || state !== 2'd2) begin
            miscompares++; $display("FAIL setmin_other: got %0d hour loads state %0d expected 0 and 2", hour_obs.size(), state);
        end
    endtask

    task automatic test_set_hour;
        logic [7:0] o;
        int n;
        press_keys(1'b0, 1'b1, 1'b0);
        vectors++;
        if (state !== 2'd3) begin miscompares++; $display("FAIL sethour_state: got %0d expected 3", state); end
        vectors++;
        if (entry_blank_hour !== 4'b0000) begin miscompares++; $display("FAIL sethour_entry_blank: got %b expected 0000", entry_blank_hour); end
        hour_exp.push_back(8'd0);
        press_keys(1'b0, 1'b0, 1'b1);
        vectors++;
        if (hour_obs.size() != 1) begin miscompares++; $display("FAIL sethour_loads: got %0d expected 1", hour_obs.size()); end
        if (hour_obs.size() > 0) begin
            o = hour_obs.pop_front();
            vectors++;
            if (o !== hour_exp[0]) begin miscompares++; $display("FAIL sethour_value: got %0d expected %0d", o, hour_exp[0]); end
        end
        hour_exp.delete();
        hour_obs.delete();
        n = 0;
        while (blank_mask !== 4'b1100 && n < 100) begin @(negedge clock); n++; end
        vectors++;
        if (blank_mask !== 4'b1100) begin miscompares++; $display("FAIL blink_on: got %b expected 1100", blank_mask); end
        n = 0;
        while (blank_mask === 4'b1100 && n < 100) begin @(negedge clock); n++; end
        vectors++;
        if (n != 40) begin miscompares++; $display("FAIL blink_on_len: got %0d clocks expected 40", n); end
        n = 0;
        while (blank_mask === 4'b0000 && n < 100) begin @(negedge clock); n++; end
        vectors++;
        if (n != 40) begin miscompares++; $display("FAIL blink_off_len: got %0d clocks expected 40", n); end
        press_keys(1'b0, 1'b1, 1'b0);
        vectors++;
        if ({state, disp_sel, blank_mask} !== 7'b0010000) begin
            miscompares++; $display("FAIL sethour_exit: got %b expected 0010000", {state, disp_sel, blank_mask});
        end
    endtask

    task automatic test_back_to_back;
        int c;
        c = clr_cnt;
        press_keys(1'b1, 1'b0, 1'b1);
        vectors++;
        if (state !== 2'd1 || clr_cnt != c) begin
            miscompares++; $display("FAIL same_cycle: got state %0d clr %0d expected 1 and 0", state, clr_cnt - c);
        end
        press_keys(1'b1, 1'b0, 1'b0);
        press_keys(1'b0, 1'b1, 1'b0);
        vectors++;
        if (state !== 2'd2) begin miscompares++; $display("FAIL b2b_setmin: got %0d expected 2", state); end
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({state, run_en, clr, load_min, load_hour, disp_sel, freeze, blank_mask, set_min, set_hour} !== 31'b0) begin
            miscompares++;
            $display("FAIL async_reset: got %h expected 0",
                     {state, run_en, clr, load_min, load_hour, disp_sel, freeze, blank_mask, set_min, set_hour});
        end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);
        vectors++;
        if (min_obs.size() != 0 || hour_obs.size() != 0) begin
            miscompares++; $display("FAIL reset_pending_load: got %0d loads expected 0", min_obs.size() + hour_obs.size());
        end
    endtask

    task automatic test_run_inc;
        press_keys(1'b1, 1'b0, 1'b0);
        press_keys(1'b0, 1'b0, 1'b1);
`ifdef LAP_FREEZE_EN
        vectors++;
        if ({freeze, disp_sel} !== 2'b10) begin miscompares++; $display("FAIL run_inc: got freeze/disp %b expected 10", {freeze, disp_sel}); end
`else
        vectors++;
        if ({freeze, disp_sel} !== 2'b01) begin miscompares++; $display("FAIL run_inc: got freeze/disp %b expected 01", {freeze, disp_sel}); end
`endif
        press_keys(1'b1, 1'b0, 1'b0);
        vectors++;
        if ({state, freeze} !== 3'b000) begin miscompares++; $display("FAIL run_exit: got %b expected 000", {state, freeze}); end
    endtask

    initial begin
        test_reset();
        test_start_run();
        test_bounce();
        test_clear();
        test_set_min();
        test_set_hour();
        test_back_to_back();
        test_run_inc();
        vectors++;
        if (overlap_cnt != 0 || bad_load_cnt != 0) begin
            miscompares++; $display("FAIL invariants: got overlap %0d bad_load %0d expected 0 0", overlap_cnt, bad_load_cnt);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
